sobel_edge_filter: RTL

Streaming 3x3 Sobel edge filter for the camera pixel path, parametrised in pixel width and image geometry. It sits between the pixel source (grey-scale conversion) and the display/threshold stage. It tracks frame position, suppresses border windows and supports a run-time mode: Gx, Gy, |Gx|+|Gy| magnitude, or passthrough. A registered edge flag against a programmable threshold is produced alongside each result.

---
 rtl/sobel_pkg.sv | 34 +++
 rtl/sobel_edge_filter_if.sv | 32 +++
 rtl/sobel_line_buffer.sv | 44 ++++
 rtl/sobel_edge_filter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming 3x3 Sobel edge filter.
// Kernel rows run top (oldest line) to bottom, columns left (oldest pixel) to right.
package sobel_pkg;

   typedef enum logic [1:0] {
      ABS_GX = 2'd0,
      ABS_GY = 2'd1,
      MAG    = 2'd2,
      PASS   = 2'd3
   } sobel_mode_e;

   typedef enum logic {
      TRK_IDLE   = 1'b0,
      TRK_ACTIVE = 1'b1
   } trk_state_e;

   localparam logic signed [2:0] GX_K [3][3] = '{
      '{-3'sd1, 3'sd0, 3'sd1},
      '{-3'sd2, 3'sd0, 3'sd2},
      '{-3'sd1, 3'sd0, 3'sd1}
   };

   localparam logic signed [2:0] GY_K [3][3] = '{
      '{-3'sd1, -3'sd2, -3'sd1},
      '{ 3'sd0,  3'sd0,  3'sd0},
      '{ 3'sd1,  3'sd2,  3'sd1}
   };

   // |Gx|+|Gy| <= 8*(2^DW-1), so three extra bits always suffice.
   function automatic int sobel_out_width(input int data_width);
      return data_width + 3;
   endfunction

endpackage

// File: rtl/sobel_edge_filter_if.sv
// Pixel-in / result-out bundle of the Sobel filter, plus tracker state for observation.
interface sobel_edge_filter_if #(
   parameter int DATA_WIDTH = 12
);
   localparam int OUT_WIDTH = sobel_pkg::sobel_out_width(DATA_WIDTH);

   // Valid-only stream, no ready: a beat transfers on every cycle its valid is
   // high, in raster order; the consumer must take every output beat.
   logic                   i_sof;
   logic                   i_val_valid;
   logic [DATA_WIDTH-1:0]  i_val;
   logic [1:0]             i_mode;
   logic [OUT_WIDTH-1:0]   i_thresh;

   logic                   o_val_valid;
   logic [OUT_WIDTH-1:0]   o_val;
   logic                   o_sof;
   logic                   o_edge;
   logic                   o_frame_err;
   sobel_pkg::trk_state_e  o_dbg_state;

   modport slave (
      input  i_sof, i_val_valid, i_val, i_mode, i_thresh,
      output o_val_valid, o_val, o_sof, o_edge, o_frame_err, o_dbg_state
   );

   modport master (
      output i_sof, i_val_valid, i_val, i_mode, i_thresh,
      input  o_val_valid, o_val, o_sof, o_edge, o_frame_err, o_dbg_state
   );

endinterface

// File: rtl/sobel_line_buffer.sv
// One-line delay: read-before-write RAM walked by a single wrapping address counter.
// Read data is the sample written exactly DEPTH enables earlier.
module sobel_line_buffer #(
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 640
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_ce,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         addr_q;
   logic [AW-1:0]         addr_d;

   always_comb begin
      addr_d = addr_q;
      if (i_ce) begin
         addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   // Contents are not reset; border suppression keeps stale lines off the output.
   always_ff @(posedge i_clk) begin
      if (i_ce) begin
         mem_q[addr_q] <= i_wr_data;
      end
   end

   assign o_rd_data = mem_q[addr_q];

endmodule

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel filter: frame tracker, line buffers, window and a two-stage
// arithmetic pipeline (Gx/Gy/centre, then mode select with threshold flag).
module sobel_edge_filter
   import sobel_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   sobel_edge_filter_if.slave  bus
);

   localparam int OUT_WIDTH = sobel_out_width(DATA_WIDTH);
   localparam int CW        = $clog2(IMG_WIDTH);
   localparam int RW        = $clog2(IMG_HEIGHT);

   typedef logic signed [OUT_WIDTH-1:0] res_t;
   typedef logic [DATA_WIDTH-1:0]       pix_t;

   // ---------------- frame tracker ----------------
   trk_state_e            state_q;
   logic [CW-1:0]         col_q;
   logic [RW-1:0]         row_q;
   sobel_mode_e           mode_q;
   logic [OUT_WIDTH-1:0]  thresh_q;
   logic                  frame_err_q;

   logic                  sof_acc;
   logic                  accept;
   logic [CW-1:0]         col_cur;
   logic [RW-1:0]         row_cur;
   logic                  last_col;
   logic                  last_row;
   logic                  win_ok;
   logic                  win_sof;

   always_comb begin
      sof_acc  = bus.i_val_valid && bus.i_sof;
      accept   = sof_acc || (bus.i_val_valid && (state_q == TRK_ACTIVE));
      col_cur  = sof_acc ? '0 : col_q;
      row_cur  = sof_acc ? '0 : row_q;
      last_col = (col_cur == CW'(IMG_WIDTH - 1));
      last_row = (row_cur == RW'(IMG_HEIGHT - 1));
      win_ok   = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
      win_sof  = win_ok && (row_cur == RW'(2)) && (col_cur == CW'(2));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= TRK_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= ABS_GX;
         thresh_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= sof_acc && (state_q == TRK_ACTIVE);
         if (sof_acc) begin
            mode_q   <= sobel_mode_e'(bus.i_mode);
            thresh_q <= bus.i_thresh;
         end
         if (accept) begin
            if (last_col) begin
               col_q <= '0;
               if (last_row) begin
                  row_q   <= '0;
                  state_q <= TRK_IDLE;
               end else begin
                  row_q   <= row_cur + RW'(1);
                  state_q <= TRK_ACTIVE;
               end
            end else begin
               col_q   <= col_cur + CW'(1);
               row_q   <= row_cur;
               state_q <= TRK_ACTIVE;
            end
         end
      end
   end

   // ---------------- line buffers and window ----------------
   pix_t lb0_rd;
   pix_t lb1_rd;

   sobel_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_ce      (accept),
      .i_wr_data (bus.i_val),
      .o_rd_data (lb0_rd)
   );

   sobel_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_ce      (accept),
      .i_wr_data (lb0_rd),
      .o_rd_data (lb1_rd)
   );

   // Two stored columns plus the live column form the window seen by this pixel.
   pix_t win_q [3][2];
   pix_t win_d [3][3];

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         win_d[i][0] = win_q[i][0];
         win_d[i][1] = win_q[i][1];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = bus.i_val;
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_d[i][1];
            win_q[i][1] <= win_d[i][2];
         end
      end
   end

   // ---------------- stage 1: gradients ----------------
   res_t gx_d;
   res_t gy_d;

   always_comb begin
      gx_d = '0;
      gy_d = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            gx_d = gx_d + res_t'(GX_K[i][j]) * res_t'({3'b000, win_d[i][j]});
            gy_d = gy_d + res_t'(GY_K[i][j]) * res_t'({3'b000, win_d[i][j]});
         end
      end
   end

   logic                 s1_valid_q;
   logic                 s1_sof_q;
   res_t                 gx_q;
   res_t                 gy_q;
   pix_t                 centre_q;
   sobel_mode_e          s1_mode_q;
   logic [OUT_WIDTH-1:0] s1_thresh_q;

   // Mode/threshold travel with the data so a new frame cannot retag old results.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         gx_q        <= '0;
         gy_q        <= '0;
         centre_q    <= '0;
         s1_mode_q   <= ABS_GX;
         s1_thresh_q <= '0;
      end else begin
         s1_valid_q <= win_ok;
         s1_sof_q   <= win_sof;
         if (win_ok) begin
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            centre_q    <= win_d[1][1];
            s1_mode_q   <= mode_q;
            s1_thresh_q <= thresh_q;
         end
      end
   end

   // ---------------- stage 2: mode select and edge flag ----------------
   logic [OUT_WIDTH-1:0] abs_x;
   logic [OUT_WIDTH-1:0] abs_y;
   logic [OUT_WIDTH-1:0] sel_d;

   always_comb begin
      abs_x = gx_q[OUT_WIDTH-1] ? OUT_WIDTH'(-gx_q) : OUT_WIDTH'(gx_q);
      abs_y = gy_q[OUT_WIDTH-1] ? OUT_WIDTH'(-gy_q) : OUT_WIDTH'(gy_q);
      case (s1_mode_q)
         ABS_GX:  sel_d = abs_x;
         ABS_GY:  sel_d = abs_y;
         MAG:     sel_d = abs_x + abs_y;
         default: sel_d = {3'b000, centre_q};
      endcase
   end

   logic                 o_val_valid_q;
   logic [OUT_WIDTH-1:0] o_val_q;
   logic                 o_sof_q;
   logic                 o_edge_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_val_valid_q <= 1'b0;
         o_val_q       <= '0;
         o_sof_q       <= 1'b0;
         o_edge_q      <= 1'b0;
      end else begin
         o_val_valid_q <= s1_valid_q;
         o_sof_q       <= s1_valid_q && s1_sof_q;
         o_edge_q      <= s1_valid_q && (sel_d >= s1_thresh_q);
         if (s1_valid_q) begin
            o_val_q <= sel_d;
         end
      end
   end

   assign bus.o_val_valid = o_val_valid_q;
   assign bus.o_val       = o_val_q;
   assign bus.o_sof       = o_sof_q;
   assign bus.o_edge      = o_edge_q;
   assign bus.o_frame_err = frame_err_q;
   assign bus.o_dbg_state = state_q;

endmodule
